// File: rtl/dmem_arbiter.sv
// Two-master front end for a byte-addressed data memory: arbitrates, builds byte
// enables and lane-replicated store data, extends load data and flags bad accesses.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 128,
  parameter bit          RR        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  we,
  input  logic [31:0] drdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

  function automatic logic access_error(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad || (addr >= ADDR_LIMIT);
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001 << off;
      2'b01:   mask = 4'b0011 << off;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      2'b00:   data = {4{wdata[7:0]}};
      2'b01:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                              input logic uns, input logic [31:0] rdata);
    logic [31:0] lane;
    logic [31:0] result;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'b00:   result = uns ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   result = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: result = rdata;
    endcase
    return result;
  endfunction

  logic [1:0]  req_vec;
  logic [1:0]  we_vec;
  logic [1:0]  uns_vec;
  logic [31:0] addr_arr  [2];
  logic [1:0]  size_arr  [2];
  logic [31:0] wdata_arr [2];

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign uns_vec      = {m1_unsigned, m0_unsigned};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign size_arr[0]  = m0_size;
  assign size_arr[1]  = m1_size;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        sel_q, sel_d;
  logic        acc_we_q, acc_we_d;
  logic [1:0]  acc_size_q, acc_size_d;
  logic        acc_uns_q, acc_uns_d;
  logic        acc_err_q, acc_err_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        win;
  logic        cand_we;
  logic [31:0] cand_addr;
  logic [1:0]  cand_size;
  logic        cand_uns;
  logic [31:0] cand_wdata;
  logic        cand_err;

  // On a tie, round-robin hands the slot to whichever master was not served last.
  always_comb begin
    win = 1'b0;
    case (req_vec)
      2'b10:   win = 1'b1;
      2'b11:   win = RR ? ~last_q : 1'b0;
      default: win = 1'b0;
    endcase
  end

  assign cand_we    = we_vec[win];
  assign cand_addr  = addr_arr[win];
  assign cand_size  = size_arr[win];
  assign cand_uns   = uns_vec[win];
  assign cand_wdata = wdata_arr[win];
  assign cand_err   = access_error(cand_addr, cand_size);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    acc_we_d   = acc_we_q;
    acc_size_d = acc_size_q;
    acc_uns_d  = acc_uns_q;
    acc_err_d  = acc_err_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    be_d       = '0;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = '0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d    = ST_ACC;
          last_d     = win;
          sel_d      = win;
          acc_we_d   = cand_we;
          acc_size_d = cand_size;
          acc_uns_d  = cand_uns;
          acc_err_d  = cand_err;
          daddr_d    = cand_addr;
          dwdata_d   = lane_data(cand_size, cand_wdata);
          be_d       = (cand_we && !cand_err) ? lane_mask(cand_size, cand_addr[1:0]) : 4'b0000;
          gnt_d[win] = 1'b1;
        end
      end
      ST_ACC: begin
        state_d         = ST_IDLE;
        rvalid_d[sel_q] = 1'b1;
        err_d           = acc_err_q;
        if (!acc_we_q && !acc_err_q) begin
          rdata_d = load_extend(acc_size_q, daddr_q[1:0], acc_uns_q, drdata);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      acc_we_q   <= 1'b0;
      acc_size_q <= 2'b00;
      acc_uns_q  <= 1'b0;
      acc_err_q  <= 1'b0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
      be_q       <= '0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      acc_we_q   <= acc_we_d;
      acc_size_q <= acc_size_d;
      acc_uns_q  <= acc_uns_d;
      acc_err_q  <= acc_err_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      be_q       <= be_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // rdata_q is only nonzero in the response cycle, so routing needs just the rvalid gate.
  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rvalid_q[0] ? rdata_q : 32'h0;
  assign m1_rdata  = rvalid_q[1] ? rdata_q : 32'h0;
  assign m0_err    = rvalid_q[0] & err_q;
  assign m1_err    = rvalid_q[1] & err_q;
  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  assign we        = be_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array reference model, per-cycle output compare,
// directed literal cases, then two randomized masters contending for the memory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_t = '0;
  logic [1:0]  we_t = '0;
  logic [1:0]  uns_t = '0;
  logic [31:0] addr_t  [2];
  logic [1:0]  size_t  [2];
  logic [31:0] wdata_t [2];

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata, daddr, dwdata, drdata;
  logic [3:0]  we;

  dmem_arbiter #(.MEM_BYTES(128), .RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_t[0]), .m0_we(we_t[0]), .m0_addr(addr_t[0]), .m0_size(size_t[0]),
    .m0_unsigned(uns_t[0]), .m0_wdata(wdata_t[0]), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(req_t[1]), .m1_we(we_t[1]), .m1_addr(addr_t[1]), .m1_size(size_t[1]),
    .m1_unsigned(uns_t[1]), .m1_wdata(wdata_t[1]), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .daddr(daddr), .dwdata(dwdata), .we(we), .drdata(drdata)
  );

  logic [1:0]  gnt_v, rvalid_v, err_v;
  logic [31:0] rdata_v [2];
  assign gnt_v      = {m1_gnt, m0_gnt};
  assign rvalid_v   = {m1_rvalid, m0_rvalid};
  assign err_v      = {m1_err, m0_err};
  assign rdata_v[0] = m0_rdata;
  assign rdata_v[1] = m1_rdata;

  // The memory the DUT drives: async read, byte-enabled write on posedge.
  logic [31:0] dmem [32];
  assign drdata = dmem[daddr[6:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) dmem[daddr[6:2]][8*b +: 8] <= dwdata[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [128];
  bit          m_busy;
  logic        m_last, m_w;
  logic        p_we, p_uns, p_err;
  logic [31:0] p_addr, p_wdata;
  logic [1:0]  p_size;
  logic [1:0]  e_gnt, e_rvalid, e_err;
  logic [31:0] e_rdata [2];
  logic [3:0]  e_we;
  logic [31:0] e_daddr, e_dwdata;

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1'b1; m_w = 1'b0;
    e_gnt = '0; e_rvalid = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    e_we = '0; e_daddr = '0; e_dwdata = '0;
  endtask

  task automatic model_step();
    int nb;
    logic [31:0] v;
    e_gnt = '0; e_rvalid = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0; e_we = '0;
    if (m_busy) begin
      m_busy = 0;
      e_rvalid[m_w] = 1'b1;
      e_err[m_w] = p_err;
      if (!p_err) begin
        nb = nbytes(p_size);
        if (p_we) begin
          for (int i = 0; i < nb; i++) ref_mem[int'(p_addr) + i] = p_wdata[8*i +: 8];
        end else begin
          v = '0;
          for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(p_addr) + i];
          if (!p_uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
          e_rdata[m_w] = v;
        end
      end
    end else if (req_t != 2'b00) begin
      m_w = (req_t == 2'b11) ? ~m_last : req_t[1];
      p_we = we_t[m_w]; p_addr = addr_t[m_w]; p_size = size_t[m_w];
      p_uns = uns_t[m_w]; p_wdata = wdata_t[m_w];
      if (p_size == 2'b11) p_err = 1'b1;
      else p_err = ((p_addr % nbytes(p_size)) != 0) || (p_addr >= 128);
      e_gnt[m_w] = 1'b1;
      e_daddr = p_addr;
      if (p_we && !p_err) begin
        nb = nbytes(p_size);
        e_we = 4'(((1 << nb) - 1) << (p_addr % 4));
        for (int b = 0; b < 4; b++) e_dwdata[8*b +: 8] = p_wdata[8*(b % nb) +: 8];
      end
      m_busy = 1;
      m_last = m_w;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every cycle the outputs are settled, compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_gnt", 32'(gnt_v), 32'(e_gnt));
      check("cyc_rvalid", 32'(rvalid_v), 32'(e_rvalid));
      check("cyc_err", 32'(err_v), 32'(e_err));
      check("cyc_rdata0", m0_rdata, e_rdata[0]);
      check("cyc_rdata1", m1_rdata, e_rdata[1]);
      check("cyc_we", 32'(we), 32'(e_we));
      check("cyc_daddr", daddr, e_daddr);
      if (e_we != 4'b0000) check("cyc_dwdata", dwdata, e_dwdata);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic txn(input int m, input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic u, input logic [31:0] wd, output logic [31:0] rd,
                     output logic er, output logic [3:0] wes, output logic [31:0] dws);
    bit got;
    rd = '0; er = 1'b0; wes = '0; dws = '0;
    @(posedge clk); #1;
    we_t[m] = w; addr_t[m] = a; size_t[m] = sz; uns_t[m] = u; wdata_t[m] = wd; req_t[m] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (gnt_v[m]) got = 1;
    end
    check("txn_gnt", 32'(got), 32'd1);
    if (!got) begin
      req_t[m] = 1'b0;
      return;
    end
    wes = we; dws = dwdata;
    @(posedge clk); #1;
    req_t[m] = 1'b0;
    @(negedge clk);
    check("txn_rvalid", 32'(rvalid_v[m]), 32'd1);
    rd = rdata_v[m]; er = err_v[m];
  endtask

  task automatic driver(input int m, input int n);
    bit got;
    int r, a, idle;
    logic [1:0] sz;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      a = $urandom_range(0, 139);
      if (sz != 2'd3 && $urandom_range(0, 4) != 0) a = a & ~((1 << sz) - 1);
      we_t[m] = 1'($urandom_range(0, 1)); uns_t[m] = 1'($urandom_range(0, 1));
      addr_t[m] = 32'(a); size_t[m] = sz; wdata_t[m] = $urandom; req_t[m] = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (gnt_v[m]) got = 1;
      end
      check("rand_gnt", 32'(got), 32'd1);
      if (!got) begin
        req_t[m] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        req_t[m] = 1'b0;
        idle = $urandom_range(0, 3);
        repeat (idle) begin
          @(posedge clk); #1;
        end
      end
    end
    req_t[m] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd, dws, w;
    logic er;
    logic [3:0] wes;
    int order[$];
    int rv_early;
    bit got;

    for (int i = 0; i < 2; i++) begin
      addr_t[i] = '0; size_t[i] = '0; wdata_t[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      dmem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_we", 32'(we), 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_gnt_rvalid", 32'({gnt_v, rvalid_v}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Word store then load back.
    txn(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, wes, dws);
    check("sw_we", 32'(wes), 32'hF);
    check("sw_dwdata", dws, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, wes, dws);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);

    // Byte store on the top lane, signed and unsigned reload.
    txn(1, 1'b1, 32'h13, 2'd0, 1'b0, 32'h80, rd, er, wes, dws);
    check("sb_we", 32'(wes), 32'b1000);
    check("sb_dwdata", dws, 32'h80808080);
    txn(1, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, rd, er, wes, dws);
    check("lb_rdata", rd, 32'hFFFFFF80);
    txn(1, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, rd, er, wes, dws);
    check("lbu_rdata", rd, 32'h00000080);
    txn(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, wes, dws);
    check("lw_after_sb", rd, 32'h80ADBEEF);

    // Error cases: misaligned, illegal size, out of range.
    txn(0, 1'b0, 32'h12, 2'd2, 1'b0, 32'h0, rd, er, wes, dws);
    check("err_lw12", 32'(er), 32'd1);
    check("err_lw12_rdata", rd, 32'd0);
    txn(1, 1'b0, 32'h11, 2'd1, 1'b0, 32'h0, rd, er, wes, dws);
    check("err_lh11", 32'(er), 32'd1);
    txn(0, 1'b1, 32'h14, 2'd3, 1'b0, 32'h55AA55AA, rd, er, wes, dws);
    check("err_size3", 32'(er), 32'd1);
    check("err_size3_we", 32'(wes), 32'd0);
    txn(1, 1'b1, 32'h80, 2'd2, 1'b0, 32'hCAFEF00D, rd, er, wes, dws);
    check("err_sw80", 32'(er), 32'd1);
    check("err_sw80_we", 32'(wes), 32'd0);
    txn(0, 1'b0, 32'h80, 2'd2, 1'b0, 32'h0, rd, er, wes, dws);
    check("err_lw80", 32'(er), 32'd1);
    check("err_lw80_rdata", rd, 32'd0);

    // Half store on the upper half of a word.
    txn(0, 1'b1, 32'h06, 2'd1, 1'b0, 32'h1234, rd, er, wes, dws);
    check("sh_we", 32'(wes), 32'b1100);
    check("sh_dwdata", dws, 32'h12341234);
    txn(0, 1'b0, 32'h06, 2'd1, 1'b0, 32'h0, rd, er, wes, dws);
    check("lh_rdata", rd, 32'h00001234);

    // Reset while a store is in ACC: aborted, no late rvalid, m0 first afterwards.
    @(posedge clk); #1;
    we_t[0] = 1'b1; addr_t[0] = 32'h20; size_t[0] = 2'd2; wdata_t[0] = 32'h11223344; req_t[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (m0_gnt) got = 1;
    end
    check("rst_acc_gnt", 32'(got), 32'd1);
    check("rst_acc_we", 32'(we), 32'hF);
    #1 rst_n = 1'b0; req_t = 2'b00;
    #1;
    check("rst_acc_we_now", 32'(we), 32'd0);
    check("rst_acc_gnt_now", 32'(gnt_v), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    we_t = 2'b00; uns_t = 2'b00;
    addr_t[0] = 32'h0; size_t[0] = 2'd2; addr_t[1] = 32'h4; size_t[1] = 2'd2;
    req_t = 2'b11;
    rv_early = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (order.size() == 0 && rvalid_v != 2'b00) rv_early++;
      if (m0_gnt) order.push_back(0);
      if (m1_gnt) order.push_back(1);
    end
    check("rst_no_rvalid", 32'(rv_early), 32'd0);
    check("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i % 2));
    @(posedge clk); #1 req_t = 2'b00;
    repeat (2) @(posedge clk);

    // Two randomized masters contending.
    fork
      driver(0, 80);
      driver(1, 80);
    join
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      check("mem_final", dmem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
